// File: rtl/fp_div_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fp_div_arb
// Purpose  : Two-requester round-robin front end for one shared, fixed-latency
//            fp_div instance. Keeps one division in flight, holds operands
//            stable across the divider latency, captures the result and flags,
//            returns them tagged with the requester id, and accumulates sticky
//            exception flags.
// Ports    : clk, rst (async, active-low)
//            req{0,1}_valid/_ready/_a/_b/_rm : requester handshakes + operands
//            div_in1/div_in2/div_round_m/div_act : drive the shared divider
//            div_out, div_ov/un/inv/div_zero/inexact : divider results
//            rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_flags : response channel
//            flags_sticky / flags_clr : accumulated flags and their clear
//            busy : arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_arb #(
  parameter int W       = 32,
  parameter int DIV_LAT = 4,
  parameter int CW      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_rm,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_rm,
  output logic [W-1:0] div_in1,
  output logic [W-1:0] div_in2,
  output logic [2:0]   div_round_m,
  output logic         div_act,
  input  logic [W-1:0] div_out,
  input  logic         div_ov,
  input  logic         div_un,
  input  logic         div_inv,
  input  logic         div_div_zero,
  input  logic         div_inexact,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic [4:0]   rsp_flags,
  output logic [4:0]   flags_sticky,
  input  logic         flags_clr,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_CNT_LOAD = CW'(DIV_LAT - 1);

  state_t         state_q, state_d;
  logic           prio_q;
  logic           id_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   opa_q, opb_q;
  logic [2:0]     rm_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [W-1:0]   rsp_data_q;
  logic [4:0]     rsp_flags_q;
  logic [4:0]     sticky_q, sticky_d;

  logic           any_req;
  logic           grant_id;
  logic           issue;
  logic           capture;
  logic           rsp_hs;
  logic [4:0]     div_flags;

  assign div_flags = {div_ov, div_un, div_inv, div_div_zero, div_inexact};

  // With a single valid requester it wins outright; on contention the
  // round-robin pointer decides.
  assign any_req  = req0_valid | req1_valid;
  assign grant_id = (req0_valid & req1_valid) ? prio_q : req1_valid;

  assign issue    = (state_q == S_IDLE) & any_req;
  // Counter reaches zero on the edge DIV_LAT cycles after issue, which is
  // when the divider's registered outputs are valid.
  assign capture  = (state_q == S_BUSY) & (cnt_q == '0);
  assign rsp_hs   = (state_q == S_RESP) & rsp_ready;

  assign req0_ready   = issue & ~grant_id;
  assign req1_ready   = issue &  grant_id;

  assign div_in1      = opa_q;
  assign div_in2      = opb_q;
  assign div_round_m  = rm_q;
  assign div_act      = (state_q == S_BUSY);
  assign busy         = (state_q != S_IDLE);

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_flags    = rsp_flags_q;
  assign flags_sticky = sticky_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (issue)   state_d = S_BUSY;
      S_BUSY:  if (capture) state_d = S_RESP;
      // Returning to IDLE on the handshake edge means no grant can happen on
      // that same edge.
      S_RESP:  if (rsp_hs)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A clear and a capture on the same edge keep the newly captured flags.
  always_comb begin
    sticky_d = (flags_clr ? 5'd0 : sticky_q) | (capture ? div_flags : 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rm_q        <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 5'd0;
      sticky_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;

      // Operand registers load only at issue, so they stay frozen through
      // BUSY and RESP.
      if (issue) begin
        opa_q  <= grant_id ? req1_a  : req0_a;
        opb_q  <= grant_id ? req1_b  : req0_b;
        rm_q   <= grant_id ? req1_rm : req0_rm;
        id_q   <= grant_id;
        cnt_q  <= C_CNT_LOAD;
        prio_q <= ~grant_id;
      end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= div_out;
        rsp_flags_q <= div_flags;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
